// File: rtl/dut_ifc_initiator.sv
// -----------------------------------------------------------------------------
// dut_ifc_initiator
//
// Purpose:
//   Drives the dut method interface (write_en/read_en with address and data)
//   from a queue of commands. Commands enter through a valid/ready port, are
//   buffered in a DEPTH-entry FIFO, and are issued one at a time by a small
//   FSM. Read results leave through a valid/ready response port. A per-command
//   timeout aborts transactions whose rdy never arrives.
//
// Handshake semantics (all ports): a transfer happens at a rising CLK edge
//   where valid and ready are both high. Once valid is raised, the payload is
//   held stable until that transfer. On the dut side, write_en/read_en are the
//   "valid" and write_rdy/read_rdy the "ready"; because en is derived from rdy,
//   a high en at an edge always means the transaction fired.
//
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command port (cmd_ready = FIFO not full)
//   cmd_op/cmd_addr/cmd_wdata        0 = write, 1 = read; address; write data
//   rsp_valid/rsp_ready              read response port
//   rsp_data/rsp_addr/rsp_err        read data, read address, timed-out flag
//   write_address/write_data/write_en/write_rdy   dut write method
//   read_address/read_en/read_data/read_rdy       dut read method
//   timeout_err                      sticky timeout indication
//   busy                             FIFO non-empty or FSM not idle
//   dbg_state                        current FSM state (0 IDLE,1 WR,2 RD,3 RESP)
// -----------------------------------------------------------------------------
module dut_ifc_initiator #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 1,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic              timeout_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW:0]       count_q, count_d;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [ENT_W-1:0]  head;
    logic              head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    state_t            state_q;

    assign fifo_full  = (count_q == (PW + 1)'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    // The FSM takes a new command only from IDLE, so at most one pop per cycle.
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    assign head                           = mem_q[rptr_q];
    assign {head_op, head_addr, head_data} = head;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wptr_q] <= {cmd_op, cmd_addr, cmd_wdata};
        end
    end

    // ---------------------------------------------------------------------
    // Issue FSM
    // ---------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CW-1:0]     tmo_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              timeout_err_q;
    logic              tmo_hit;

    // The counter holds the number of rdy-low cycles already spent; when it
    // shows TIMEOUT-1 and rdy is still low, this is the TIMEOUT-th wait cycle.
    assign tmo_hit = (TIMEOUT > 0) && (int'(tmo_q) == TIMEOUT - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            tmo_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= head_addr;
                        data_q  <= head_data;
                        tmo_q   <= '0;
                        state_q <= head_op ? S_RD : S_WR;
                    end
                end
                S_WR: begin
                    // A fire in the limit cycle wins over the abort.
                    if (write_rdy) begin
                        state_q <= S_IDLE;
                    end else if (tmo_hit) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                S_RD: begin
                    if (read_rdy) begin
                        rsp_data_q  <= read_data;
                        rsp_addr_q  <= addr_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_data_q    <= '0;
                        rsp_addr_q    <= addr_q;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + CW'(1);
                    end
                end
                S_RESP: begin
                    // Holding here blocks further issue, keeping reads ordered.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // en follows rdy so no cycle is wasted; RST gating kills a transaction
    // already in progress during the reset cycle itself.
    assign write_en      = !RST && (state_q == S_WR) && write_rdy;
    assign read_en       = !RST && (state_q == S_RD) && read_rdy;
    assign write_address = addr_q;
    assign write_data    = data_q;
    assign read_address  = addr_q;

    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_addr      = rsp_addr_q;
    assign timeout_err   = timeout_err_q;
    assign busy          = !fifo_empty || (state_q != S_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dut_ifc_initiator.sv
// -----------------------------------------------------------------------------
// tb_dut_ifc_initiator
//
// Bench for dut_ifc_initiator. A negedge monitor keeps a transaction-level
// model: accepted commands go into an expected queue, each dut-side fire must
// match the oldest outstanding command, and each read fire predicts the
// response that must later leave the response port. Directed tasks check the
// cycle-exact behaviour (latency, stalls, FIFO full, timeout, reset).
// -----------------------------------------------------------------------------
module tb_dut_ifc_initiator;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 1;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CMD_W   = 1 + ADDR_W + DATA_W;
  localparam int RSP_W   = ADDR_W + DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_op = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy = 1'b0;
  logic [ADDR_W-1:0] read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data = '0;
  logic              read_rdy = 1'b0;
  logic              timeout_err;
  logic              busy;
  logic [1:0]        dbg_state;

  dut_ifc_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data),
    .read_rdy(read_rdy), .timeout_err(timeout_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_fires = 0;
  int rd_fires = 0;
  int rsp_seen = 0;
  bit mon_en = 1'b0;
  bit rand_rd = 1'b0;
  bit rand_rdy = 1'b0;

  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];
  logic [CMD_W-1:0] m_cmd;
  logic [RSP_W-1:0] m_rsp;

  always @(negedge clk) begin
    if (!rst) begin
      if (write_en) wr_fires++;
      if (read_en) rd_fires++;
      if (rsp_valid && rsp_ready) rsp_seen++;
      vec_cnt++;
      if (write_en && read_en) begin
        err_cnt++;
        $display("FAIL en_exclusive: write_en=%0b read_en=%0b, required not both high", write_en, read_en);
      end
      if (mon_en) begin
        if (write_en) begin
          vec_cnt++;
          if (exp_cmd_q.size() == 0) begin
            err_cnt++;
            $display("FAIL wr_order: write fired addr=%0d with no outstanding command", write_address);
          end else begin
            m_cmd = exp_cmd_q.pop_front();
            if ({1'b0, write_address, write_data} !== m_cmd) begin
              err_cnt++;
              $display("FAIL wr_order: got op/addr/data=%h, required %h", {1'b0, write_address, write_data}, m_cmd);
            end
          end
        end
        if (read_en) begin
          vec_cnt++;
          if (exp_cmd_q.size() == 0) begin
            err_cnt++;
            $display("FAIL rd_order: read fired addr=%0d with no outstanding command", read_address);
          end else begin
            m_cmd = exp_cmd_q.pop_front();
            if ({1'b1, read_address} !== m_cmd[CMD_W-1:DATA_W]) begin
              err_cnt++;
              $display("FAIL rd_order: got op/addr=%h, required %h", {1'b1, read_address}, m_cmd[CMD_W-1:DATA_W]);
            end
            exp_rsp_q.push_back({m_cmd[ADDR_W+DATA_W-1:DATA_W], read_data, 1'b0});
          end
        end
        if (rsp_valid && rsp_ready) begin
          vec_cnt++;
          if (exp_rsp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL rsp_order: response addr=%0d with no outstanding read", rsp_addr);
          end else begin
            m_rsp = exp_rsp_q.pop_front();
            if ({rsp_addr, rsp_data, rsp_err} !== m_rsp) begin
              err_cnt++;
              $display("FAIL rsp_value: got addr/data/err=%h, required %h", {rsp_addr, rsp_data, rsp_err}, m_rsp);
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          exp_cmd_q.push_back({cmd_op, cmd_addr, cmd_op ? DATA_W'(0) : cmd_wdata});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rd) read_data = DATA_W'($urandom);
    if (rand_rdy) begin
      write_rdy = ($urandom_range(0, 3) != 0);
      read_rdy  = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic send_cmd(input logic op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = addr;
    cmd_wdata = data;
    #0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (!cmd_ready) begin
      err_cnt++;
      $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while ((busy || rsp_valid) && n < max_cyc) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (busy || rsp_valid) begin
      err_cnt++;
      $display("FAIL %s: busy=%0b rsp_valid=%0b after %0d cycles, required idle", name, busy, rsp_valid, max_cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({cmd_ready, rsp_valid, rsp_err, timeout_err, busy, write_en, read_en} !== 7'b1000000) begin
      err_cnt++;
      $display("FAIL reset_flags: got rdy/rv/re/te/busy/we/re=%b, required 1000000",
               {cmd_ready, rsp_valid, rsp_err, timeout_err, busy, write_en, read_en});
    end
    vec_cnt++;
    if ({rsp_data, rsp_addr, write_address, write_data, read_address} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h, required 0", {rsp_data, rsp_addr, write_address, write_data, read_address});
    end
  endtask

  task automatic test_reset_mid_rd();
    int r0;
    read_rdy = 1'b0;
    send_cmd(1'b1, ADDR_W'(5), DATA_W'(0));
    tick();
    tick();
    vec_cnt++;
    if (busy !== 1'b1 || read_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrd_stall: busy=%0b read_en=%0b, required 1 0", busy, read_en);
    end
    rst = 1'b1;
    read_rdy = 1'b1;
    #1;
    vec_cnt++;
    if (read_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrd_gate: read_en=%0b during reset cycle, required 0", read_en);
    end
    r0 = rd_fires;
    tick();
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    #1;
    vec_cnt++;
    if ({busy, cmd_ready, rsp_valid, read_en} !== 4'b0100) begin
      err_cnt++;
      $display("FAIL midrd_after: busy/cmd_ready/rsp_valid/read_en=%b, required 0100", {busy, cmd_ready, rsp_valid, read_en});
    end
    repeat (3) tick();
    vec_cnt++;
    if (rd_fires != r0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrd_dropped: read fires=%0d busy=%0b, required 0 0", rd_fires - r0, busy);
    end
    read_rdy = 1'b0;
  endtask

  task automatic test_single_write();
    write_rdy = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_addr = ADDR_W'(4);
    cmd_wdata = DATA_W'(1);
    tick();                      // edge k: accepted
    cmd_valid = 1'b0;
    vec_cnt++;
    if (write_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_early: write_en=%0b in cycle k..k+1, required 0", write_en);
    end
    tick();                      // edge k+1: popped
    vec_cnt++;
    if ({write_en, write_address, write_data} !== {1'b1, ADDR_W'(4), DATA_W'(1)}) begin
      err_cnt++;
      $display("FAIL wr_issue: en/addr/data=%h, required %h", {write_en, write_address, write_data}, {1'b1, ADDR_W'(4), DATA_W'(1)});
    end
    tick();                      // edge k+2: fired
    vec_cnt++;
    if (write_en !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_done: write_en=%0b busy=%0b, required 0 0", write_en, busy);
    end
    write_rdy = 1'b0;
  endtask

  task automatic test_read_stall();
    int w0;
    logic [RSP_W+1:0] held;
    read_rdy = 1'b0;
    write_rdy = 1'b1;
    rsp_ready = 1'b0;
    read_data = '0;
    w0 = wr_fires;
    send_cmd(1'b1, ADDR_W'(3), DATA_W'(0));
    send_cmd(1'b0, ADDR_W'(5), DATA_W'(0));
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (read_en !== 1'b0 || write_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL rd_stall: cycle %0d read_en=%0b write_en=%0b, required 0 0", i, read_en, write_en);
      end
      tick();
    end
    read_rdy = 1'b1;
    read_data = DATA_W'(1);
    #1;
    vec_cnt++;
    if (read_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL rd_fire: read_en=%0b in rdy cycle, required 1", read_en);
    end
    tick();
    read_rdy = 1'b0;
    read_data = '0;
    held = {rsp_valid, rsp_data, rsp_addr, rsp_err, busy};
    vec_cnt++;
    if (held !== {1'b1, DATA_W'(1), ADDR_W'(3), 1'b0, 1'b1}) begin
      err_cnt++;
      $display("FAIL rd_rsp: valid/data/addr/err/busy=%h, required %h", held, {1'b1, DATA_W'(1), ADDR_W'(3), 1'b0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if ({rsp_valid, rsp_data, rsp_addr, rsp_err, busy} !== held || write_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL rsp_hold: cycle %0d rsp=%h write_en=%0b, required %h 0", i,
                 {rsp_valid, rsp_data, rsp_addr, rsp_err, busy}, write_en, held);
      end
    end
    vec_cnt++;
    if (wr_fires != w0) begin
      err_cnt++;
      $display("FAIL rsp_block: %0d writes issued during RESP, required 0", wr_fires - w0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rsp_clear: rsp_valid=%0b after handshake, required 0", rsp_valid);
    end
    wait_idle(50, "rd_stall_drain");
    vec_cnt++;
    if (wr_fires - w0 != 1) begin
      err_cnt++;
      $display("FAIL rd_stall_wr: %0d writes fired, required 1", wr_fires - w0);
    end
    write_rdy = 1'b0;
  endtask

  task automatic test_fifo_full();
    int w0;
    write_rdy = 1'b0;
    w0 = wr_fires;
    // One command moves into the FSM, DEPTH more fill the FIFO.
    for (int i = 0; i < DEPTH + 1; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 1'b0;
      cmd_addr = ADDR_W'(i);
      cmd_wdata = DATA_W'($urandom);
      #1;
      vec_cnt++;
      if (cmd_ready !== 1'b1) begin
        err_cnt++;
        $display("FAIL fifo_accept: cmd %0d cmd_ready=%0b, required 1", i, cmd_ready);
      end
      tick();
    end
    cmd_addr = ADDR_W'(DEPTH + 1);
    #1;
    vec_cnt++;
    if (cmd_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL fifo_full: cmd_ready=%0b with FIFO full, required 0", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    vec_cnt++;
    if (cmd_ready !== 1'b0 || wr_fires != w0) begin
      err_cnt++;
      $display("FAIL fifo_still_full: cmd_ready=%0b fires=%0d, required 0 0", cmd_ready, wr_fires - w0);
    end
    write_rdy = 1'b1;
    wait_idle(100, "fifo_drain");
    vec_cnt++;
    if (wr_fires - w0 != DEPTH + 1) begin
      err_cnt++;
      $display("FAIL fifo_fires: %0d writes fired, required %0d", wr_fires - w0, DEPTH + 1);
    end
    write_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    int w0;
    mon_en = 1'b0;
    read_rdy = 1'b0;
    rsp_ready = 1'b0;
    read_data = DATA_W'(1);
    send_cmd(1'b1, ADDR_W'(6), DATA_W'(0));
    tick();                          // into RD
    repeat (TIMEOUT - 1) tick();     // now in the TIMEOUT-th wait cycle
    vec_cnt++;
    if (rsp_valid !== 1'b0 || timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL tmo_early: rsp_valid=%0b timeout_err=%0b before limit, required 0 0", rsp_valid, timeout_err);
    end
    tick();
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_addr, timeout_err} !== {1'b1, 1'b1, DATA_W'(0), ADDR_W'(6), 1'b1}) begin
      err_cnt++;
      $display("FAIL tmo_rsp: valid/err/data/addr/terr=%h, required %h",
               {rsp_valid, rsp_err, rsp_data, rsp_addr, timeout_err}, {1'b1, 1'b1, DATA_W'(0), ADDR_W'(6), 1'b1});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec_cnt++;
    if (rsp_valid !== 1'b0 || timeout_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL tmo_sticky: rsp_valid=%0b timeout_err=%0b, required 0 1", rsp_valid, timeout_err);
    end
    // rdy rising in the limit cycle: the fire wins
    send_cmd(1'b1, ADDR_W'(2), DATA_W'(0));
    tick();
    repeat (TIMEOUT - 1) tick();
    read_rdy = 1'b1;
    #1;
    vec_cnt++;
    if (read_en !== 1'b1) begin
      err_cnt++;
      $display("FAIL tmo_race_en: read_en=%0b in limit cycle, required 1", read_en);
    end
    tick();
    read_rdy = 1'b0;
    vec_cnt++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_addr} !== {1'b1, 1'b0, DATA_W'(1), ADDR_W'(2)}) begin
      err_cnt++;
      $display("FAIL tmo_race_rsp: valid/err/data/addr=%h, required %h",
               {rsp_valid, rsp_err, rsp_data, rsp_addr}, {1'b1, 1'b0, DATA_W'(1), ADDR_W'(2)});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // write timeout: command dropped
    write_rdy = 1'b0;
    w0 = wr_fires;
    send_cmd(1'b0, ADDR_W'(7), DATA_W'(1));
    tick();
    repeat (TIMEOUT) tick();
    vec_cnt++;
    if (busy !== 1'b0 || wr_fires != w0 || timeout_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL tmo_wr: busy=%0b fires=%0d timeout_err=%0b, required 0 0 1", busy, wr_fires - w0, timeout_err);
    end
    write_rdy = 1'b1;
    repeat (2) tick();
    vec_cnt++;
    if (wr_fires != w0) begin
      err_cnt++;
      $display("FAIL tmo_wr_drop: %0d writes after abort, required 0", wr_fires - w0);
    end
    write_rdy = 1'b0;
    read_data = '0;
    do_reset();
    vec_cnt++;
    if (timeout_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL tmo_reset: timeout_err=%0b after reset, required 0", timeout_err);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_mixed();
    int w0, r0, s0;
    write_rdy = 1'b1;
    read_rdy = 1'b1;
    rsp_ready = 1'b1;
    rand_rd = 1'b1;
    w0 = wr_fires;
    r0 = rd_fires;
    s0 = rsp_seen;
    send_cmd(1'b0, ADDR_W'(4), DATA_W'(1));
    send_cmd(1'b0, ADDR_W'(5), DATA_W'(0));
    send_cmd(1'b1, ADDR_W'(3), DATA_W'(0));
    wait_idle(50, "mixed_drain");
    vec_cnt++;
    if (wr_fires - w0 != 2 || rd_fires - r0 != 1 || rsp_seen - s0 != 1) begin
      err_cnt++;
      $display("FAIL mixed_count: wr=%0d rd=%0d rsp=%0d, required 2 1 1", wr_fires - w0, rd_fires - r0, rsp_seen - s0);
    end
    rand_rd = 1'b0;
  endtask

  task automatic test_random();
    rand_rd = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_cmd(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle(2000, "random_drain");
    rand_rdy = 1'b0;
    rand_rd = 1'b0;
    write_rdy = 1'b0;
    read_rdy = 1'b0;
    rsp_ready = 1'b0;
    tick();
    vec_cnt++;
    if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL random_leftover: %0d commands and %0d responses outstanding, required 0 0",
               exp_cmd_q.size(), exp_rsp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    mon_en = 1'b1;
    test_reset_mid_rd();
    test_single_write();
    test_read_stall();
    test_fifo_full();
    test_timeout();
    test_mixed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
